// File: rtl/mm_disp_pkg.sv
// Shared types, constants and helpers for the multimeter BCD display stage.
// Used by rms_bcd_disp and mm_seg7_enc.
package mm_disp_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Active-low segments, bit 0 = a ... bit 6 = g; index = nibble value 0..F
    localparam logic [15:0][6:0] SEG7_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    localparam logic [6:0] SEG7_OFF = 7'h7F;

    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] nibble);
        logic [BCD_W-1:0] res;
        if (nibble >= 4'd5) begin
            res = nibble + 4'd3;
        end else begin
            res = nibble;
        end
        return res;
    endfunction

endpackage

// File: rtl/mm_seg7_enc.sv
// One BCD digit plus blank flag to active-low 7-segment pattern (combinational).
// Only instantiated when RMS_BCD_SEVSEG_EN is defined.
module mm_seg7_enc
    import mm_disp_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    input  logic             blank,
    output logic [6:0]       seg
);

    // Blanked digits are fully dark
    always_comb begin
        seg = SEG7_OFF;
        if (blank) begin
            seg = SEG7_OFF;
        end else begin
            seg = SEG7_TABLE[digit];
        end
    end

endmodule

// File: rtl/rms_bcd_disp.sv
// Binary RMS result to packed BCD via sequential double dabble, with leading-zero
// blank mask and overflow flag. Optional 7-segment output under RMS_BCD_SEVSEG_EN.
module rms_bcd_disp
    import mm_disp_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DIGITS = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_W-1:0]         din_i,
    input  logic                      din_update_i,
    input  logic                      clr_i,
    output logic [DIGITS*BCD_W-1:0]   bcd_o,
    output logic [DIGITS-1:0]         blank_o,
    output logic                      ovf_o,
    output logic                      busy_o,
    output logic                      dout_update_o
`ifdef RMS_BCD_SEVSEG_EN
    ,
    output logic [DIGITS*7-1:0]       seg_o
`endif
);

    localparam int BCD_BITS = DIGITS * BCD_W;
    localparam int SR_W     = BCD_BITS + DATA_W;
    localparam int CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

    state_t                state_r, state_next_s;
    logic [CNT_W-1:0]      bit_cnt_r;
    logic [SR_W-1:0]       sr_r, adj_s, sr_step_s;
    logic                  carry_s, ovf_sticky_r;
    logic                  load_s, finish_s;
    logic [DATA_W-1:0]     load_data_s;
    logic                  pend_valid_r;
    logic [DATA_W-1:0]     pend_data_r;
    logic                  res_ovf_s;
    logic [BCD_BITS-1:0]   bcd_next_s;
    logic [DIGITS-1:0]     blank_next_s;
    logic [BCD_BITS-1:0]   bcd_r;
    logic [DIGITS-1:0]     blank_r;
    logic                  ovf_r, busy_r, upd_r;

    // One double-dabble step: adjust every nibble, then shift the whole register left
    always_comb begin
        adj_s = sr_r;
        for (int i = 0; i < DIGITS; i++) begin
            adj_s[DATA_W + i*BCD_W +: BCD_W] = add3(sr_r[DATA_W + i*BCD_W +: BCD_W]);
        end
        sr_step_s = {adj_s[SR_W-2:0], 1'b0};
        carry_s   = adj_s[SR_W-1];
    end

    // A waiting value always takes precedence over a fresh strobe
    always_comb begin
        load_data_s = din_i;
        if (pend_valid_r) begin
            load_data_s = pend_data_r;
        end else begin
            load_data_s = din_i;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (din_update_i || pend_valid_r) begin
                    state_next_s = SHIFT;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (bit_cnt_r == CNT_LAST) begin
                    state_next_s = DONE;
                    finish_s     = 1'b1;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Result of the final shift, formatted for the display (overflow shows all 9s)
    always_comb begin
        logic zero_run;
        res_ovf_s    = ovf_sticky_r | carry_s;
        bcd_next_s   = sr_step_s[SR_W-1 -: BCD_BITS];
        blank_next_s = {DIGITS{1'b0}};
        zero_run     = 1'b1;
        if (res_ovf_s) begin
            bcd_next_s   = {DIGITS{4'h9}};
            blank_next_s = {DIGITS{1'b0}};
        end else begin
            for (int i = DIGITS - 1; i >= 1; i--) begin
                zero_run        = zero_run & (bcd_next_s[i*BCD_W +: BCD_W] == 4'h0);
                blank_next_s[i] = zero_run;
            end
        end
    end

    // FSM state, bit counter and busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            bit_cnt_r <= {CNT_W{1'b0}};
            busy_r    <= 1'b0;
        end else if (clr_i) begin
            state_r   <= IDLE;
            bit_cnt_r <= {CNT_W{1'b0}};
            busy_r    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != IDLE);
            if (load_s || (state_r == SHIFT && bit_cnt_r == CNT_LAST)) begin
                bit_cnt_r <= {CNT_W{1'b0}};
            end else if (state_r == SHIFT) begin
                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
        end
    end

    // Conversion shift register and sticky carry-out of the top digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_r         <= {SR_W{1'b0}};
            ovf_sticky_r <= 1'b0;
        end else if (clr_i) begin
            sr_r         <= {SR_W{1'b0}};
            ovf_sticky_r <= 1'b0;
        end else if (load_s) begin
            sr_r         <= {{BCD_BITS{1'b0}}, load_data_s};
            ovf_sticky_r <= 1'b0;
        end else if (state_r == SHIFT) begin
            sr_r         <= sr_step_s;
            ovf_sticky_r <= ovf_sticky_r | carry_s;
        end else begin
            sr_r         <= sr_r;
            ovf_sticky_r <= ovf_sticky_r;
        end
    end

    // Pending slot: a strobe that is not loaded directly is parked (latest wins)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_r <= 1'b0;
            pend_data_r  <= {DATA_W{1'b0}};
        end else if (clr_i) begin
            pend_valid_r <= 1'b0;
            pend_data_r  <= {DATA_W{1'b0}};
        end else if (din_update_i && !(load_s && !pend_valid_r)) begin
            pend_valid_r <= 1'b1;
            pend_data_r  <= din_i;
        end else if (load_s && pend_valid_r) begin
            pend_valid_r <= 1'b0;
            pend_data_r  <= pend_data_r;
        end else begin
            pend_valid_r <= pend_valid_r;
            pend_data_r  <= pend_data_r;
        end
    end

    // Display outputs update on entry to DONE so the pulse coincides with DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_r   <= {BCD_BITS{1'b0}};
            blank_r <= BLANK_RST;
            ovf_r   <= 1'b0;
            upd_r   <= 1'b0;
        end else if (clr_i) begin
            bcd_r   <= {BCD_BITS{1'b0}};
            blank_r <= BLANK_RST;
            ovf_r   <= 1'b0;
            upd_r   <= 1'b0;
        end else if (finish_s) begin
            bcd_r   <= bcd_next_s;
            blank_r <= blank_next_s;
            ovf_r   <= res_ovf_s;
            upd_r   <= 1'b1;
        end else begin
            bcd_r   <= bcd_r;
            blank_r <= blank_r;
            ovf_r   <= ovf_r;
            upd_r   <= 1'b0;
        end
    end

    assign bcd_o         = bcd_r;
    assign blank_o       = blank_r;
    assign ovf_o         = ovf_r;
    assign busy_o        = busy_r;
    assign dout_update_o = upd_r;

`ifdef RMS_BCD_SEVSEG_EN
    localparam logic [DIGITS*7-1:0] SEG_RST = {{(DIGITS-1){7'h7F}}, 7'h40};

    logic [DIGITS*7-1:0] seg_next_s;
    logic [DIGITS*7-1:0] seg_r;

    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        mm_seg7_enc u_enc (
            .digit (bcd_next_s[g*BCD_W +: BCD_W]),
            .blank (blank_next_s[g]),
            .seg   (seg_next_s[g*7 +: 7])
        );
    end

    // Segment register tracks bcd_o
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r <= SEG_RST;
        end else if (clr_i) begin
            seg_r <= SEG_RST;
        end else if (finish_s) begin
            seg_r <= seg_next_s;
        end else begin
            seg_r <= seg_r;
        end
    end

    assign seg_o = seg_r;
`endif

endmodule

// File: tb/tb_rms_bcd_disp.sv
// Self-checking bench for rms_bcd_disp: 5-digit main instance plus a 4-digit
// instance for overflow; seg_o checked when RMS_BCD_SEVSEG_EN is defined.
module tb_rms_bcd_disp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] din;
    logic        din_update;
    logic        clr;
    logic [19:0] bcd;
    logic [4:0]  blank;
    logic        ovf, busy, upd;

    logic [15:0] din4;
    logic        din_update4;
    logic        clr4;
    logic [15:0] bcd4;
    logic [3:0]  blank4;
    logic        ovf4, busy4, upd4;

`ifdef RMS_BCD_SEVSEG_EN
    logic [34:0] seg;
    logic [27:0] seg4;
    logic [6:0]  seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
`endif

    int errors = 0;
    int checks = 0;

    logic [19:0] q_bcd[$];
    logic [4:0]  q_blank[$];
    logic        q_ovf[$];
    int          q_time[$];

    always #5 clk = ~clk;

    rms_bcd_disp #(.DATA_W(16), .DIGITS(5)) dut (
        .clk(clk), .rst_n(rst_n), .din_i(din), .din_update_i(din_update), .clr_i(clr),
        .bcd_o(bcd), .blank_o(blank), .ovf_o(ovf), .busy_o(busy), .dout_update_o(upd)
`ifdef RMS_BCD_SEVSEG_EN
        , .seg_o(seg)
`endif
    );

    rms_bcd_disp #(.DATA_W(16), .DIGITS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .din_i(din4), .din_update_i(din_update4), .clr_i(clr4),
        .bcd_o(bcd4), .blank_o(blank4), .ovf_o(ovf4), .busy_o(busy4), .dout_update_o(upd4)
`ifdef RMS_BCD_SEVSEG_EN
        , .seg_o(seg4)
`endif
    );

    // ---------------- reference model (decimal arithmetic) ----------------
    function automatic int pow10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [19:0] ref_bcd(input int v, input int nd);
        logic [19:0] r = 20'h0;
        for (int i = 0; i < nd; i++) begin
            if (v >= pow10(nd)) r[i*4 +: 4] = 4'h9;
            else                r[i*4 +: 4] = 4'((v / pow10(i)) % 10);
        end
        return r;
    endfunction

    function automatic logic [4:0] ref_blank(input int v, input int nd);
        logic [4:0] r = 5'b0;
        if (v < pow10(nd)) begin
            for (int i = 1; i < nd; i++) r[i] = (v < pow10(i));
        end
        return r;
    endfunction

`ifdef RMS_BCD_SEVSEG_EN
    function automatic logic [34:0] ref_seg(input int v);
        logic [34:0] r;
        logic [19:0] b = ref_bcd(v, 5);
        logic [4:0]  k = ref_blank(v, 5);
        for (int i = 0; i < 5; i++) r[i*7 +: 7] = k[i] ? 7'h7F : seg_tab[b[i*4 +: 4]];
        return r;
    endfunction
`endif

    // Drive up to three strobes at given cycle offsets; record every output pulse
    task automatic run_strobes(input bit on4, input int t0, input int t1, input int t2,
                               input logic [15:0] v0, input logic [15:0] v1,
                               input logic [15:0] v2, input int horizon);
        logic        s;
        logic [15:0] v;
        q_bcd.delete(); q_blank.delete(); q_ovf.delete(); q_time.delete();
        for (int k = 0; k < horizon; k++) begin
            @(negedge clk);
            if (!on4 && upd) begin
                q_bcd.push_back(bcd); q_blank.push_back(blank);
                q_ovf.push_back(ovf); q_time.push_back(k);
            end
            if (on4 && upd4) begin
                q_bcd.push_back({4'h0, bcd4}); q_blank.push_back({1'b0, blank4});
                q_ovf.push_back(ovf4); q_time.push_back(k);
            end
            s = 1'b0; v = 16'h0;
            if (k == t0)      begin s = 1'b1; v = v0; end
            else if (k == t1) begin s = 1'b1; v = v1; end
            else if (k == t2) begin s = 1'b1; v = v2; end
            if (on4) begin din_update4 = s; din4 = v; end
            else     begin din_update  = s; din  = v; end
        end
        din_update  = 1'b0;
        din_update4 = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        checks++;
        if (bcd !== 20'h0 || blank !== 5'b11110 || ovf !== 1'b0 || busy !== 1'b0 || upd !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: bcd=%h blank=%b ovf=%b busy=%b upd=%b, want 00000 11110 0 0 0",
                     bcd, blank, ovf, busy, upd);
        end
`ifdef RMS_BCD_SEVSEG_EN
        checks++;
        if (seg !== {{4{7'h7F}}, 7'h40}) begin
            errors++;
            $display("FAIL reset_seg: got %h want %h", seg, {{4{7'h7F}}, 7'h40});
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        run_strobes(1'b0, 0, -1, -1, 16'd4321, 16'd0, 16'd0, 20);
        run_strobes(1'b0, 0, -1, -1, 16'd777, 16'd0, 16'd0, 6);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy_before: busy=%b want 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bcd !== 20'h0 || blank !== 5'b11110 || ovf !== 1'b0 || busy !== 1'b0 || upd !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: bcd=%h blank=%b ovf=%b busy=%b upd=%b, want 00000 11110 0 0 0",
                     bcd, blank, ovf, busy, upd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_strobes(1'b0, -1, -1, -1, 16'd0, 16'd0, 16'd0, 30);
        checks++;
        if (q_time.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_pulse: pulses=%0d busy=%b, want 0 0", q_time.size(), busy);
        end
    endtask

    task automatic test_convert(input bit on4, input logic [15:0] v);
        int nd = on4 ? 4 : 5;
        run_strobes(on4, 0, -1, -1, v, 16'd0, 16'd0, 24);
        checks++;
        if (q_time.size() != 1) begin
            errors++;
            $display("FAIL latency(%0d): got %0d pulses, want 1", v, q_time.size());
        end else if (q_time[0] != 17) begin
            errors++;
            $display("FAIL latency(%0d): pulse at %0d, want 17", v, q_time[0]);
        end
        if (q_time.size() >= 1) begin
            checks++;
            if (q_bcd[0] !== ref_bcd(int'(v), nd)) begin
                errors++;
                $display("FAIL bcd(%0d,d%0d): got %h want %h", v, nd, q_bcd[0], ref_bcd(int'(v), nd));
            end
            checks++;
            if (q_blank[0] !== ref_blank(int'(v), nd)) begin
                errors++;
                $display("FAIL blank(%0d,d%0d): got %b want %b", v, nd, q_blank[0], ref_blank(int'(v), nd));
            end
            checks++;
            if (q_ovf[0] !== (int'(v) >= pow10(nd))) begin
                errors++;
                $display("FAIL ovf(%0d,d%0d): got %b want %b", v, nd, q_ovf[0], int'(v) >= pow10(nd));
            end
        end
        checks++;
        if ((on4 ? busy4 : busy) !== 1'b0) begin
            errors++;
            $display("FAIL idle_after(%0d): busy still 1", v);
        end
    endtask

    task automatic test_directed();
        logic [15:0] vals [8] = '{16'd1234, 16'd0, 16'd65535, 16'd9, 16'd10, 16'd99, 16'd100, 16'd10000};
        foreach (vals[i]) test_convert(1'b0, vals[i]);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            if (i % 3 == 0) test_convert(1'b0, 16'($urandom_range(0, 999)));
            else            test_convert(1'b0, 16'($urandom_range(0, 65535)));
        end
    endtask

    task automatic test_overflow();
        logic [15:0] vals [5] = '{16'd12345, 16'd9999, 16'd10000, 16'd65535, 16'd0};
        foreach (vals[i]) test_convert(1'b1, vals[i]);
        test_convert(1'b1, 16'($urandom_range(10000, 65535)));
    endtask

    task automatic test_back_to_back();
        int          t [3];
        logic [15:0] v [3];
        logic [15:0] ev [3];
        int          et [3];
        int          n;
        for (int sc = 0; sc < 3; sc++) begin
            v[0] = 16'($urandom_range(0, 65535));
            v[1] = 16'($urandom_range(0, 65535));
            v[2] = 16'($urandom_range(0, 65535));
            et[0] = 17; et[1] = 34; et[2] = 51;
            if (sc == 0) begin
                t[0] = 0; t[1] = 3; t[2] = 8;
                v[0] = 16'd100; v[1] = 16'd200; v[2] = 16'd300;
                ev[0] = v[0]; ev[1] = v[2]; n = 2;
            end else if (sc == 1) begin
                t[0] = 0; t[1] = 5; t[2] = 17;
                ev[0] = v[0]; ev[1] = v[1]; ev[2] = v[2]; n = 3;
            end else begin
                t[0] = 0; t[1] = 17; t[2] = -1;
                ev[0] = v[0]; ev[1] = v[1]; n = 2;
            end
            run_strobes(1'b0, t[0], t[1], t[2], v[0], v[1], v[2], 60);
            checks++;
            if (q_time.size() != n) begin
                errors++;
                $display("FAIL b2b_count(sc%0d): got %0d pulses want %0d", sc, q_time.size(), n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    checks++;
                    if (q_time[i] != et[i] || q_bcd[i] !== ref_bcd(int'(ev[i]), 5)) begin
                        errors++;
                        $display("FAIL b2b(sc%0d,#%0d): got t=%0d bcd=%h want t=%0d bcd=%h",
                                 sc, i, q_time[i], q_bcd[i], et[i], ref_bcd(int'(ev[i]), 5));
                    end
                end
            end
        end
    endtask

    task automatic test_clear();
        run_strobes(1'b0, 0, -1, -1, 16'd1234, 16'd0, 16'd0, 20);
        run_strobes(1'b0, 0, 2, -1, 16'd999, 16'd555, 16'd0, 6);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (busy !== 1'b0 || bcd !== 20'h0 || blank !== 5'b11110 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL clear_state: busy=%b bcd=%h blank=%b ovf=%b, want 0 00000 11110 0",
                     busy, bcd, blank, ovf);
        end
        run_strobes(1'b0, -1, -1, -1, 16'd0, 16'd0, 16'd0, 30);
        checks++;
        if (q_time.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_no_pulse: pulses=%0d busy=%b, want 0 0", q_time.size(), busy);
        end
    endtask

`ifdef RMS_BCD_SEVSEG_EN
    task automatic test_seg();
        logic [15:0] vals [3] = '{16'd8, 16'd0, 16'd40917};
        foreach (vals[i]) begin
            run_strobes(1'b0, 0, -1, -1, vals[i], 16'd0, 16'd0, 20);
            checks++;
            if (seg !== ref_seg(int'(vals[i]))) begin
                errors++;
                $display("FAIL seg(%0d): got %h want %h", vals[i], seg, ref_seg(int'(vals[i])));
            end
        end
        run_strobes(1'b1, 0, -1, -1, 16'd12345, 16'd0, 16'd0, 20);
        checks++;
        if (seg4 !== {4{7'h10}}) begin
            errors++;
            $display("FAIL seg_ovf: got %h want %h", seg4, {4{7'h10}});
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        din = 16'h0; din_update = 1'b0; clr = 1'b0;
        din4 = 16'h0; din_update4 = 1'b0; clr4 = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_directed();
        test_random();
        test_overflow();
        test_back_to_back();
        test_clear();
`ifdef RMS_BCD_SEVSEG_EN
        test_seg();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
